// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: a valid/ready command becomes one
// bus cycle, and its result (or a timeout error) comes back as a valid/ready response.
module wb_initiator #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic [15:0]     txn_count
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Timer value seen in the last permitted STB cycle; STB is then high TIMEOUT cycles.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q;
    logic              we_q;
    logic [AW-1:0]     adr_q;
    logic [DW-1:0]     dat_q;
    logic [DW/8-1:0]   sel_q;
    logic [DW-1:0]     rsp_dat_q;
    logic              rsp_err_q;
    logic [15:0]       txn_q;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        wbm_cyc_o = (state_q == BUS);
        wbm_stb_o = (state_q == BUS);
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timer_q   <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            txn_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        adr_q   <= cmd_adr;
                        dat_q   <= cmd_dat;
                        sel_q   <= cmd_sel;
                        timer_q <= '0;
                    end
                end
                BUS: begin
                    // ACK takes priority over a simultaneous timeout expiry.
                    if (wbm_ack_i) begin
                        rsp_dat_q <= we_q ? '0 : wbm_dat_i;
                        rsp_err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) txn_q <= txn_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_q;

endmodule
